// File: rtl/image_loader.sv
// rtl/image_loader.sv - packs received RGB332 bytes into 32-bit words and writes a frame to BaseRAM
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN adds an 8-bit running checksum output.
module image_loader #(
    parameter int          WORDS     = 120000,
    parameter int          WE_CYCLES = 2,
    parameter logic [19:0] BASE_ADDR = 20'h00000
) (
    input  logic        clk_10M,
    input  logic        reset_of_clk10M,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [19:0] word_count,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
`ifdef IMAGE_LOADER_CHECKSUM_EN
    output logic [7:0]  checksum,
`endif
    output logic [3:0]  sram_be_n
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        SETUP   = 3'd2,
        WRITE   = 3'd3,
        HOLD    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [19:0] WORDS_L = 20'(WORDS);
    localparam logic [3:0]  WE_LAST = 4'(WE_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    logic        pending;
    logic [19:0] packed_cnt;
    logic [3:0]  we_cnt;
    logic        start_ok;
    logic        accept;
    logic        word_done;
    logic        hold_exit;
    logic        bus_active;

    assign sram_oe_n = 1'b1;
    assign sram_be_n = 4'b0000;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    // Decode byte acceptance, word completion and the next FSM state.
    always_comb begin
        start_ok   = start && ((state == IDLE) || (state == DONE));
        accept     = rx_valid && (state != IDLE) && (state != DONE) && (packed_cnt < WORDS_L);
        word_done  = accept && (byte_cnt == 2'd3);
        hold_exit  = (state == HOLD);
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COLLECT;
            DONE:    if (start) next_state = COLLECT;
            COLLECT: if (pending) next_state = SETUP;
            SETUP:   next_state = WRITE;
            WRITE:   if (we_cnt == WE_LAST) next_state = HOLD;
            HOLD:    next_state = ((word_count + 20'd1) >= WORDS_L) ? DONE : COLLECT;
            default: next_state = IDLE;
        endcase
        bus_active = (next_state == SETUP) || (next_state == WRITE) || (next_state == HOLD);
    end

    // FSM state register.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) state <= IDLE;
        else                 state <= next_state;
    end

    // Byte packer: little-endian assembly, pending handshake and overrun detection.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            byte_cnt   <= 2'd0;
            byte_buf   <= 24'd0;
            pending    <= 1'b0;
            packed_cnt <= 20'd0;
            overrun    <= 1'b0;
            sram_wdata <= 32'd0;
        end else if (start_ok) begin
            byte_cnt   <= 2'd0;
            byte_buf   <= 24'd0;
            pending    <= 1'b0;
            packed_cnt <= 20'd0;
            overrun    <= 1'b0;
        end else begin
            if (hold_exit) pending <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    byte_buf[7:0]   <= rx_data;
                    2'd1:    byte_buf[15:8]  <= rx_data;
                    2'd2:    byte_buf[23:16] <= rx_data;
                    default: byte_buf        <= byte_buf;
                endcase
            end
            // A word finishing on the HOLD exit cycle replaces the one just written.
            if (word_done) begin
                if (pending && !hold_exit) begin
                    overrun <= 1'b1;
                end else begin
                    sram_wdata <= {rx_data, byte_buf};
                    pending    <= 1'b1;
                    packed_cnt <= packed_cnt + 20'd1;
                end
            end
        end
    end

    // Write sequencing: address latch, WE pulse width counter and word counter.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            word_count <= 20'd0;
            sram_addr  <= 20'd0;
            we_cnt     <= 4'd0;
        end else begin
            if (start_ok) begin
                word_count <= 20'd0;
            end else if (hold_exit && (word_count < WORDS_L)) begin
                word_count <= word_count + 20'd1;
            end
            if ((state == COLLECT) && pending) sram_addr <= BASE_ADDR + word_count;
            we_cnt <= (state == WRITE) ? (we_cnt + 4'd1) : 4'd0;
        end
    end

    // Registered strobes track the next state so they line up with the state and drop glitch-free on reset.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            sram_ce_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
        end else begin
            sram_ce_n    <= !bus_active;
            sram_we_n    <= (next_state != WRITE);
            sram_data_oe <= bus_active;
        end
    end

`ifdef IMAGE_LOADER_CHECKSUM_EN
    // Modulo-256 sum of accepted bytes; naturally frozen in DONE since nothing is accepted there.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M)  checksum <= 8'd0;
        else if (start_ok)    checksum <= 8'd0;
        else if (accept)      checksum <= checksum + rx_data;
    end
`endif

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter WORDS, default 120000, is the number of 32-bit words per frame (800x600 bytes / 4).
REQ-002 Parameter WE_CYCLES, default 2, is the number of clk_10M cycles sram_we_n is held low per write; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 20'h00000, is the first BaseRAM word address written.
REQ-004 clk_10M  in  1  system clock; every register is clocked on its rising edge.
REQ-005 reset_of_clk10M  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a frame load.
REQ-007 rx_valid  in  1  single-cycle strobe marking rx_data as a valid received byte.
REQ-008 rx_data  in  8  received pixel byte, RGB332.
REQ-009 busy  out  1  high from the cycle after an accepted start until DONE is entered.
REQ-010 done  out  1  high while in DONE.
REQ-011 overrun  out  1  sticky flag: a packed word was dropped.
REQ-012 word_count  out  20  number of words written in the current load.
REQ-013 sram_addr  out  20  BaseRAM word address.
REQ-014 sram_wdata  out  32  BaseRAM write data.
REQ-015 sram_data_oe  out  1  high means the parent drives sram_wdata onto base_ram_data.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  BaseRAM strobes, all active-low.
REQ-017 sram_be_n  out  4  constant 4'b0000.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT, SETUP, WRITE, HOLD and DONE.
REQ-019 start in IDLE or DONE SHALL clear word_count and overrun, empty the packer, and move the FSM to COLLECT; start in any other state SHALL be ignored.
REQ-020 The packer SHALL place the bytes of each word little-endian: the 1st byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-021 The packer SHALL accept rx_valid in every state except IDLE and DONE; rx_valid in IDLE or DONE SHALL be discarded.
REQ-022 Completion of the 4th byte SHALL copy the packed word into sram_wdata and set pending, in the same cycle as that byte's rx_valid.
REQ-023 If a word completes while pending is already set, the new word SHALL be dropped, overrun SHALL be set, and pending SHALL stay set.
REQ-024 COLLECT with pending set SHALL go to SETUP on the next cycle.
REQ-025 In SETUP (1 cycle): sram_addr = BASE_ADDR + word_count, sram_data_oe=1, sram_ce_n=0, sram_we_n=1.
REQ-026 In WRITE (WE_CYCLES cycles): sram_we_n=0, with address, data and ce unchanged.
REQ-027 In HOLD (1 cycle): sram_we_n=1 and sram_data_oe=1; on exit, clear pending and increment word_count.
REQ-028 On HOLD exit, the FSM SHALL go to DONE if the incremented word_count equals WORDS, otherwise to COLLECT.
REQ-029 Each write SHALL take exactly WE_CYCLES+2 cycles; address and data SHALL be stable throughout the write.
REQ-030 In every state other than SETUP, WRITE and HOLD: sram_ce_n=1, sram_we_n=1, sram_data_oe=0.
REQ-031 sram_oe_n SHALL be constantly 1.
REQ-032 word_count SHALL saturate at WORDS, and sram_addr SHALL not wrap past BASE_ADDR+WORDS-1.
REQ-033 A byte arriving in the same cycle as the HOLD exit SHALL be accepted, and it SHALL complete a word only when it is the 4th byte.
REQ-034 Bytes beyond WORDS*4 SHALL be discarded.

Reset
REQ-035 Reset SHALL force IDLE, busy=0, done=0, overrun=0, word_count=0, pending=0, packer empty, sram_addr=0, sram_wdata=0, sram_data_oe=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1.
REQ-036 Reset asserted mid-write SHALL raise sram_we_n and sram_ce_n asynchronously, and the write SHALL be abandoned.

Configuration
REQ-037 With IMAGE_LOADER_CHECKSUM_EN defined: an extra output checksum[7:0] SHALL hold the modulo-256 sum of all accepted bytes; it is cleared by start and by reset, and is frozen in DONE.
REQ-038 Without IMAGE_LOADER_CHECKSUM_EN: the checksum port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-039 Reset, then start, then bytes 11,22,33,44: one write to addr 0 with data 32'h44332211, we_n low for 2 cycles, word_count=1.
REQ-040 WORDS=3, 12 bytes: three writes to addr 0,1,2, then done=1 and busy=0; a 13th byte causes no write.
REQ-041 Back-to-back rx_valid for 8 bytes (WE_CYCLES=2): the second word completes while pending is set, so overrun=1 and exactly one write occurs for those 8 bytes.
REQ-042 Reset asserted during WRITE: we_n=1 and ce_n=1 in the same delta, and the FSM is in IDLE after release.
REQ-043 start pulsed during COLLECT after 2 bytes: no effect, and the next 2 bytes complete word 0.
REQ-044 With IMAGE_LOADER_CHECKSUM_EN, bytes FF,01,02,03: checksum=8'h05.
